// File: rtl/imu_pkg.sv
// Shared types and MPU-6050 constants for the IMU motion scanner.
package imu_pkg;

    typedef enum logic [2:0] {
        INIT_REG,
        INIT_DATA,
        IDLE,
        SET_PTR,
        READ,
        EVAL,
        BACKOFF
    } scan_state_e;

    localparam logic [7:0] MPU_ACCEL_XOUT_H = 8'h3B;
    localparam logic [7:0] MPU_PWR_MGMT_1   = 8'h6B;
    localparam logic [7:0] MPU_DEV_ADDR     = 8'h68;

    typedef logic signed [15:0] sample_t;

endpackage

// File: rtl/axis_motion_eval.sv
// Per-axis motion detector: scan-to-scan |delta| against a threshold with a
// hold counter that keeps the flag up for a number of scans.
module axis_motion_eval
    import imu_pkg::*;
#(
    parameter logic [15:0] THRESH     = 16'd1024,
    parameter int          HOLD_SCANS = 4
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    eval_strobe,
    input  logic    prev_valid,
    input  sample_t new_sample,
    input  sample_t prev_sample,
    output logic    move
);

    localparam int HW = $clog2(HOLD_SCANS + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_SCANS);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    logic signed [16:0] delta;
    logic [16:0]        abs_delta;
    logic               exceed;
    logic [HW-1:0]      hold_q, hold_d;

    // An invalid previous sample clears the hold so a re-synced sensor starts quiet.
    always_comb begin
        delta     = {new_sample[15], new_sample} - {prev_sample[15], prev_sample};
        abs_delta = delta[16] ? $unsigned(-delta) : $unsigned(delta);
        exceed    = abs_delta > {1'b0, THRESH};
        hold_d    = hold_q;
        if (eval_strobe) begin
            if (!prev_valid) begin
                hold_d = '0;
            end else if (exceed) begin
                hold_d = HOLD_LOAD;
            end else if (hold_q != '0) begin
                hold_d = hold_q - HOLD_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign move = (hold_q != '0);

endmodule

// File: rtl/imu_motion_scanner.sv
// Periodic I2C register-scan sequencer for an MPU-6050 style IMU: wakes the
// sensor, reads N_AXES big-endian axis words per scan and flags motion.
module imu_motion_scanner
    import imu_pkg::*;
#(
    parameter int          N_AXES     = 3,
    parameter logic [7:0]  BASE_REG   = MPU_ACCEL_XOUT_H,
    parameter logic [7:0]  WAKE_REG   = MPU_PWR_MGMT_1,
    parameter logic [15:0] THRESH     = 16'd1024,
    parameter logic [23:0] SCAN_DIV   = 24'd500000,
    parameter int          HOLD_SCANS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    output logic                  i2c_req,
    output logic                  i2c_rw,
    output logic [7:0]            i2c_wdata,
    output logic                  i2c_stop,
    input  logic                  i2c_ack,
    input  logic                  i2c_rvalid,
    input  logic [7:0]            i2c_rdata,
    input  logic                  i2c_nack,
    output logic [16*N_AXES-1:0]  sample,
    output logic                  sample_valid,
    output logic [N_AXES-1:0]     axis_move,
    output logic                  movement,
    output logic [7:0]            nack_count
);

    localparam int RW = $clog2(2 * N_AXES) + 1;
    localparam logic [RW-1:0] RD_LAST   = RW'(2 * N_AXES - 1);
    localparam logic [RW-1:0] RD_ONE    = RW'(1);
    localparam logic [23:0]   TIMER_MAX = SCAN_DIV - 24'd1;

    scan_state_e           state_q, state_d;
    logic [23:0]           timer_q, timer_d;
    logic                  req_q, req_d, rw_q, rw_d, stop_q, stop_d;
    logic [7:0]            wdata_q, wdata_d;
    logic                  await_q, await_d;
    logic [RW-1:0]         rd_cnt_q, rd_cnt_d;
    logic [16*N_AXES-1:0]  shadow_q, shadow_d, sample_q, sample_d;
    logic                  sample_valid_q, sample_valid_d;
    logic                  prev_valid_q, prev_valid_d;
    logic [7:0]            nack_cnt_q, nack_cnt_d;
    logic                  eval_strobe;
    int                    byte_off;

    // Command fields are registered when req rises so they stay stable until ack.
    always_comb begin
        state_d        = state_q;
        timer_d        = (timer_q == TIMER_MAX) ? timer_q : timer_q + 24'd1;
        req_d          = req_q;
        rw_d           = rw_q;
        wdata_d        = wdata_q;
        stop_d         = stop_q;
        await_d        = await_q;
        rd_cnt_d       = rd_cnt_q;
        shadow_d       = shadow_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        prev_valid_d   = prev_valid_q;
        nack_cnt_d     = nack_cnt_q;
        eval_strobe    = 1'b0;
        byte_off       = 16 * (int'(rd_cnt_q) >> 1) + (rd_cnt_q[0] ? 0 : 8);

        case (state_q)
            INIT_REG, INIT_DATA, SET_PTR: begin
                if (!req_q) begin
                    req_d   = 1'b1;
                    rw_d    = 1'b0;
                    wdata_d = (state_q == INIT_REG) ? WAKE_REG :
                              (state_q == SET_PTR)  ? BASE_REG : 8'h00;
                    stop_d  = (state_q != INIT_REG);
                end else if (i2c_ack) begin
                    req_d    = 1'b0;
                    rd_cnt_d = '0;
                    state_d  = (state_q == INIT_REG)  ? INIT_DATA :
                               (state_q == INIT_DATA) ? IDLE : READ;
                end
            end
            IDLE: begin
                if (timer_q == TIMER_MAX && enable) begin
                    timer_d = '0;
                    state_d = SET_PTR;
                end
            end
            READ: begin
                if (req_q && i2c_ack) begin
                    req_d   = 1'b0;
                    await_d = 1'b1;
                end else if (!req_q && !await_q) begin
                    req_d   = 1'b1;
                    rw_d    = 1'b1;
                    wdata_d = 8'h00;
                    stop_d  = (rd_cnt_q == RD_LAST);
                end
                if (i2c_rvalid && (await_q || (req_q && i2c_ack))) begin
                    shadow_d[byte_off +: 8] = i2c_rdata;
                    await_d = 1'b0;
                    if (rd_cnt_q == RD_LAST) begin
                        state_d = EVAL;
                    end else begin
                        rd_cnt_d = rd_cnt_q + RD_ONE;
                    end
                end
            end
            EVAL: begin
                eval_strobe    = 1'b1;
                sample_d       = shadow_q;
                sample_valid_d = 1'b1;
                prev_valid_d   = 1'b1;
                state_d        = IDLE;
            end
            BACKOFF: begin
                if (timer_q == TIMER_MAX) begin
                    state_d = INIT_REG;
                end
            end
            default: state_d = INIT_REG;
        endcase

        // A NACK overrides any concurrent ack or data byte.
        if (i2c_nack) begin
            state_d        = BACKOFF;
            timer_d        = '0;
            req_d          = 1'b0;
            await_d        = 1'b0;
            rd_cnt_d       = '0;
            shadow_d       = shadow_q;
            sample_d       = sample_q;
            sample_valid_d = 1'b0;
            prev_valid_d   = 1'b0;
            eval_strobe    = 1'b0;
            nack_cnt_d     = (nack_cnt_q == 8'hFF) ? nack_cnt_q : nack_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= INIT_REG;
            timer_q        <= '0;
            req_q          <= 1'b0;
            rw_q           <= 1'b0;
            wdata_q        <= '0;
            stop_q         <= 1'b0;
            await_q        <= 1'b0;
            rd_cnt_q       <= '0;
            shadow_q       <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            prev_valid_q   <= 1'b0;
            nack_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            req_q          <= req_d;
            rw_q           <= rw_d;
            wdata_q        <= wdata_d;
            stop_q         <= stop_d;
            await_q        <= await_d;
            rd_cnt_q       <= rd_cnt_d;
            shadow_q       <= shadow_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            prev_valid_q   <= prev_valid_d;
            nack_cnt_q     <= nack_cnt_d;
        end
    end

    // The published sample doubles as the previous scan for delta evaluation.
    for (genvar i = 0; i < N_AXES; i++) begin : g_axis
        axis_motion_eval #(
            .THRESH     (THRESH),
            .HOLD_SCANS (HOLD_SCANS)
        ) u_eval (
            .clk         (clk),
            .reset_n     (reset_n),
            .eval_strobe (eval_strobe),
            .prev_valid  (prev_valid_q),
            .new_sample  (shadow_q[16*i +: 16]),
            .prev_sample (sample_q[16*i +: 16]),
            .move        (axis_move[i])
        );
    end

    assign i2c_req      = req_q;
    assign i2c_rw       = rw_q;
    assign i2c_wdata    = wdata_q;
    assign i2c_stop     = stop_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign movement     = |axis_move;
    assign nack_count   = nack_cnt_q;

endmodule

// File: tb/tb_imu_motion_scanner.sv
// Self-checking bench: I2C byte-master model plus a scan-level reference model
// of the motion flags, driven with directed and randomized axis data.
module tb_imu_motion_scanner;

    localparam int          NAX  = 3;
    localparam logic [23:0] SDIV = 24'd200;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic              i2c_req, i2c_rw, i2c_stop;
    logic [7:0]        i2c_wdata;
    logic              i2c_ack = 1'b0, i2c_rvalid = 1'b0, i2c_nack = 1'b0;
    logic [7:0]        i2c_rdata = 8'h00;
    logic [16*NAX-1:0] sample;
    logic              sample_valid, movement;
    logic [NAX-1:0]    axis_move;
    logic [7:0]        nack_count;

    imu_motion_scanner #(
        .N_AXES   (NAX),
        .SCAN_DIV (SDIV)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .i2c_req      (i2c_req),
        .i2c_rw       (i2c_rw),
        .i2c_wdata    (i2c_wdata),
        .i2c_stop     (i2c_stop),
        .i2c_ack      (i2c_ack),
        .i2c_rvalid   (i2c_rvalid),
        .i2c_rdata    (i2c_rdata),
        .i2c_nack     (i2c_nack),
        .sample       (sample),
        .sample_valid (sample_valid),
        .axis_move    (axis_move),
        .movement     (movement),
        .nack_count   (nack_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0] vals [NAX];
    logic [9:0]  cmd_log [$];
    int          cmd_cyc [$];
    int          cyc = 0, n_cmds = 0, sv_count = 0, scan_rd = 0;
    int          ack_delay = 0, nack_countdown = -1;
    int          nack_cyc = 0, last_sv_cyc = 0, ptr_rise = 0;

    int prev_m [NAX];
    int hold_m [NAX];
    bit pv_m = 0;

    // Byte-command master: ack after ack_delay cycles of req, read data one cycle later.
    initial begin
        int wait_cnt = 0, rise_cyc = 0, idx;
        bit pend = 0;
        logic [7:0] pend_byte = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            i2c_ack = 1'b0; i2c_rvalid = 1'b0; i2c_nack = 1'b0; i2c_rdata = 8'h00;
            if (!reset_n) begin
                wait_cnt = 0; pend = 0;
                continue;
            end
            if (sample_valid === 1'b1) begin
                sv_count++;
                last_sv_cyc = cyc;
            end
            if (pend) begin
                i2c_rvalid = 1'b1; i2c_rdata = pend_byte; pend = 0;
            end
            if (i2c_req === 1'b1) begin
                if (wait_cnt == 0) rise_cyc = cyc;
                if (wait_cnt >= ack_delay) begin
                    wait_cnt = 0;
                    if (i2c_rw && nack_countdown == 0) begin
                        i2c_nack = 1'b1; nack_countdown = -1; nack_cyc = cyc;
                    end else begin
                        i2c_ack = 1'b1;
                        cmd_log.push_back({i2c_rw, i2c_wdata, i2c_stop});
                        cmd_cyc.push_back(cyc);
                        n_cmds++;
                        if (!i2c_rw && i2c_wdata == 8'h3B) begin
                            scan_rd = 0; ptr_rise = rise_cyc;
                        end
                        if (i2c_rw) begin
                            if (nack_countdown > 0) nack_countdown--;
                            idx = (scan_rd / 2) % NAX;
                            pend = 1;
                            pend_byte = scan_rd[0] ? vals[idx][7:0] : vals[idx][15:8];
                            scan_rd++;
                        end
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #(600000);
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scan-level reference: strict |delta| > 1024 reloads a 4-scan hold.
    task automatic modelEval(output logic [NAX-1:0] mv);
        int nv, d;
        for (int a = 0; a < NAX; a++) begin
            nv = int'($signed(vals[a]));
            if (!pv_m) begin
                hold_m[a] = 0;
            end else begin
                d = nv - prev_m[a];
                if (d < 0) d = -d;
                if (d > 1024) hold_m[a] = 4;
                else if (hold_m[a] > 0) hold_m[a]--;
            end
            prev_m[a] = nv;
            mv[a] = (hold_m[a] != 0);
        end
        pv_m = 1;
    endtask

    task automatic waitSample(input string tag);
        int k = 0;
        while (sample_valid !== 1'b1 && k < 3000) begin
            tick(1);
            k++;
        end
        checkOutput({tag, "_valid"}, 64'(sample_valid), 64'd1);
    endtask

    task automatic applyStimulus(input string tag, input logic [15:0] v0, input logic [15:0] v1,
                                 input logic [15:0] v2);
        logic [NAX-1:0] mv;
        vals[0] = v0; vals[1] = v1; vals[2] = v2;
        waitSample(tag);
        modelEval(mv);
        checkOutput({tag, "_sample"}, 64'(sample), 64'({v2, v1, v0}));
        checkOutput({tag, "_move"}, 64'(axis_move), 64'(mv));
        checkOutput({tag, "_movement"}, 64'(movement), 64'(|mv));
        tick(1);
    endtask

    initial begin
        logic [9:0]  exp_cmd;
        logic [15:0] nv [NAX];
        int snap_cmds, snap_sv;

        vals[0] = 16'h0100; vals[1] = 16'h1234; vals[2] = 16'hF000;
        tick(3);
        checkOutput("rst_req", 64'(i2c_req), 64'd0);
        checkOutput("rst_cmd", 64'({i2c_rw, i2c_wdata, i2c_stop}), 64'd0);
        checkOutput("rst_valid", 64'(sample_valid), 64'd0);
        checkOutput("rst_sample", 64'(sample), 64'd0);
        checkOutput("rst_move", 64'({axis_move, movement}), 64'd0);
        checkOutput("rst_nack", 64'(nack_count), 64'd0);

        reset_n = 1'b1;
        enable = 1'b1;
        applyStimulus("first", 16'h0100, 16'h1234, 16'hF000);
        checkOutput("first_ncmd", 64'(cmd_log.size()), 64'(3 + 2 * NAX));
        for (int i = 0; i < 3 + 2 * NAX; i++) begin
            if (i == 0)      exp_cmd = {1'b0, 8'h6B, 1'b0};
            else if (i == 1) exp_cmd = {1'b0, 8'h00, 1'b1};
            else if (i == 2) exp_cmd = {1'b0, 8'h3B, 1'b1};
            else             exp_cmd = {1'b1, 8'h00, (i == 2 + 2 * NAX)};
            checkOutput($sformatf("first_cmd%0d", i), 64'(cmd_log[i]), 64'(exp_cmd));
        end

        $display("[TB] directed threshold scans");
        for (int s = 0; s < 5; s++) applyStimulus($sformatf("hold%0d", s), 16'h0501, 16'h1234, 16'hF000);
        applyStimulus("eq1024", 16'h0501, 16'h1634, 16'h0000);
        applyStimulus("neg1025", 16'h0501, 16'h1634, 16'hFBFF);

        $display("[TB] randomized scans");
        for (int s = 0; s < 12; s++) begin
            for (int a = 0; a < NAX; a++) begin
                case ($urandom_range(0, 5))
                    0: nv[a] = vals[a] + 16'd1024;
                    1: nv[a] = vals[a] - 16'd1024;
                    2: nv[a] = vals[a] + 16'd1025;
                    3: nv[a] = vals[a] - 16'd1025;
                    4: nv[a] = vals[a];
                    default: nv[a] = 16'($urandom());
                endcase
            end
            applyStimulus($sformatf("rnd%0d", s), nv[0], nv[1], nv[2]);
        end

        $display("[TB] enable dropped mid-read");
        snap_cmds = n_cmds;
        begin
            int k = 0;
            while (n_cmds < snap_cmds + 3 && k < 1000) begin
                tick(1);
                k++;
            end
        end
        enable = 1'b0;
        applyStimulus("endrop", vals[0], vals[1], vals[2]);
        snap_cmds = n_cmds;
        snap_sv = sv_count;
        tick(3 * int'(SDIV));
        checkOutput("endrop_nocmd", 64'(n_cmds), 64'(snap_cmds));
        checkOutput("endrop_nosv", 64'(sv_count), 64'(snap_sv));
        checkOutput("endrop_req", 64'(i2c_req), 64'd0);
        enable = 1'b1;
        applyStimulus("enback", 16'h7000, vals[1], vals[2]);

        $display("[TB] nack on third read");
        snap_sv = sv_count;
        nack_countdown = 2;
        begin
            int k = 0;
            while (nack_count == 8'd0 && k < 1000) begin
                tick(1);
                k++;
            end
        end
        checkOutput("nack_count", 64'(nack_count), 64'd1);
        checkOutput("nack_nosv", 64'(sv_count), 64'(snap_sv));
        cmd_log.delete();
        cmd_cyc.delete();
        pv_m = 0;
        applyStimulus("after_nack", 16'h7FFF, 16'h8000, 16'h0000);
        checkOutput("renit_cmd0", 64'(cmd_log[0]), 64'({1'b0, 8'h6B, 1'b0}));
        checkOutput("renit_cmd1", 64'(cmd_log[1]), 64'({1'b0, 8'h00, 1'b1}));
        checkOutput("renit_cmd2", 64'(cmd_log[2]), 64'({1'b0, 8'h3B, 1'b1}));
        checkOutput("backoff_len", 64'(cmd_cyc[0] - nack_cyc >= int'(SDIV)), 64'd1);
        checkOutput("nack_hold", 64'(nack_count), 64'd1);
        applyStimulus("post_nack", 16'h7FFF, 16'h8000, 16'h0401);

        $display("[TB] overrun with slow acks");
        ack_delay = 30;
        applyStimulus("slow0", 16'h1111, 16'h2222, 16'h3333);
        applyStimulus("slow1", 16'h1111, 16'h2A22, 16'h3333);
        tick(45);
        checkOutput("backtoback", 64'((ptr_rise - last_sv_cyc >= 1) && (ptr_rise - last_sv_cyc <= 4)), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imu_motion_scanner.md
# imu_motion_scanner

Parametrised successor to the single-axis MPU-6050 front end: a periodic register-scan sequencer that wakes an I2C IMU and reads N_AXES consecutive big-endian 16-bit axis registers every scan period. It drives the existing `i2c_master` byte-command interface and assembles signed samples. It flags per-axis motion when the scan-to-scan delta exceeds a threshold, with a hold time. It sits between `i2c_master` and game/UI logic, replacing the fixed 8-bit single-register compare path.

## Interface
- N_AXES, 3, axes read per scan, legal range 1..6
- BASE_REG, 8'h3B, first data register address (ACCEL_XOUT_H)
- WAKE_REG, 8'h6B, power-management register written at init
- THRESH, 16'd1024, unsigned motion threshold on |delta|
- SCAN_DIV, 24'd500000, clk cycles between scan starts, minimum 64
- HOLD_SCANS, 4, scans a motion flag stays set after the last exceedance, minimum 1
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  scanning permitted
- i2c_req  out  1  byte command request, held until acked
- i2c_rw  out  1  1 = read byte, 0 = write byte
- i2c_wdata  out  8  write byte; don't-care for reads
- i2c_stop  out  1  issue STOP after this byte
- i2c_ack  in  1  one-cycle pulse: command accepted
- i2c_rvalid  in  1  one-cycle pulse: read byte available
- i2c_rdata  in  8  read byte, valid with i2c_rvalid
- i2c_nack  in  1  one-cycle pulse: slave NACK, transaction aborted
- sample  out  16*N_AXES  signed axis samples, axis 0 in bits [15:0]
- sample_valid  out  1  one-cycle pulse: new sample set
- axis_move  out  N_AXES  per-axis motion flag
- movement  out  1  OR of axis_move
- nack_count  out  8  saturating NACK counter

## Operation
- States: INIT_REG, INIT_DATA, IDLE, SET_PTR, READ, EVAL, BACKOFF.
- INIT_REG writes WAKE_REG with stop=0. INIT_DATA writes 8'h00 with stop=1. Both then go to IDLE.
- IDLE waits until the scan timer reaches SCAN_DIV-1 and enable=1. It then restarts the timer and goes to SET_PTR.
- SET_PTR writes BASE_REG with stop=1, then goes to READ.
- READ issues 2*N_AXES read commands. Only one read is outstanding: the next request is raised after i2c_rvalid. The last read carries stop=1.
- Bytes are assembled as high byte first, low byte second, and stored in an internal shadow. `sample` is updated only in EVAL.
- EVAL:
  - copies the shadow to `sample`
  - computes delta = new - prev per axis, 17-bit signed
  - takes |delta| as 17-bit unsigned
  - treats |delta| > THRESH (strictly greater) as an exceedance
  - then returns to IDLE
- On an exceedance the axis hold counter loads HOLD_SCANS. Otherwise it decrements, saturating at 0. axis_move[i] = (hold[i] != 0).
- The first EVAL after reset or after BACKOFF has prev invalid: it stores prev only, all hold counters are cleared, and no exceedance is flagged.
- enable=0 never aborts a transaction sequence. The current init or scan completes through its stop byte, then the block parks in IDLE with outputs held.
- An i2c_nack in any state:
  - drops i2c_req the next cycle
  - increments nack_count, saturating at 255
  - invalidates prev
  - enters BACKOFF.
- BACKOFF waits SCAN_DIV cycles, then re-enters INIT_REG so the sensor is woken again.

## Timing
- Reset values: all outputs 0. State is INIT_REG, scan timer 0, prev invalid.
- Request rule:
  - i2c_rw, i2c_wdata and i2c_stop are stable while i2c_req=1.
  - i2c_ack may arrive in the cycle i2c_req rises.
  - i2c_req is low for at least one cycle after each ack.
- sample_valid, the new `sample` and the updated axis_move all appear in the same cycle, one clk after the cycle in which the final i2c_rvalid is captured.
- If a scan overruns SCAN_DIV, the next scan starts on the first IDLE cycle (timer saturated, no skipped count accumulation).
- i2c_nack coinciding with i2c_ack or i2c_rvalid: the NACK wins, and the data byte is discarded.
- Reset asserted mid-transaction: all state and outputs return to reset values immediately; no stop is issued.

## Structure
- Shared package `imu_pkg` holds:
  - the state enumeration
  - MPU-6050 register constants (8'h3B, 8'h6B, 8'h68 device address)
  - the 16-bit sample type
- One sub-module, `axis_motion_eval`, is instantiated N_AXES times in a generate loop.
  - Inputs: new sample, prev, prev_valid, eval strobe.
  - Owns the delta, abs, compare and hold counter.
  - Outputs: the move flag.
- The sequencer, byte assembly and scan timer live in the top.

## Test plan
- Reset release with an ack-immediate master model -> command writes 8'h6B (stop=0), 8'h00 (stop=1), 8'h3B (stop=1), then 6 reads, last with stop=1; first sample_valid has axis_move=0.
- Axis 0 reads 0x0100, then 0x0501 on the next scan (delta 1025 > 1024) -> axis_move=3'b001, movement=1 for exactly 4 sample_valid pulses with no further change.
- Delta exactly 1024, and delta -1025 (0x0000 -> 0xFBFF) -> no flag, then flag set.
- i2c_nack on the third read -> nack_count=1; no sample_valid that scan; SCAN_DIV cycles later the init writes repeat; the first subsequent EVAL flags nothing.
- Drop enable mid-READ -> remaining reads plus stop complete and sample_valid pulses once; no further i2c_req until enable returns.
- N_AXES=1, SCAN_DIV=64, with a master delaying ack 100 cycles -> scans start back-to-back; sample[15:0] matches the driven bytes.
